// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the shared 4-bit transfer bus: grants one master
// at a time, forces a one-cycle turnaround between owners and revokes overlong holds.
module bus_arbiter #(
  parameter int          NREQ      = 3,
  parameter int          TIMEOUT   = 64,
  parameter logic [3:0]  IDLE_ADDR = 4'b1111
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NREQ-1:0]   i_req,
  input  logic [4*NREQ-1:0] i_addr_in,
  input  logic [NREQ-1:0]   i_val_in,
  input  logic              i_clr_err,
  output logic [NREQ-1:0]   o_gnt,
  output logic [3:0]        o_addr,
  output logic              o_val,
  output logic              o_busy,
  output logic [1:0]        o_owner,
  output logic              o_timeout_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_TURN  = 2'd2;
  localparam logic [1:0] LAST     = 2'(NREQ - 1);
  localparam logic [7:0] HOLD_MAX = 8'(TIMEOUT - 1);

  logic [1:0]      r_state;
  logic [1:0]      r_ptr;
  logic [1:0]      r_owner;
  logic [NREQ-1:0] r_gnt;
  logic [7:0]      r_cnt;
  logic [NREQ-1:0] r_mask;
  logic            r_timeout_err;

  // Per-master views padded to four slots so a 2-bit index is always in range.
  logic [3:0]      w_req_pad;
  logic [3:0]      w_elig_pad;
  logic [3:0]      w_val_pad;
  logic [3:0]      w_addr_arr [4];
  logic [1:0]      w_scan;
  logic            w_pick_valid;
  logic [1:0]      w_pick_idx;
  logic [NREQ-1:0] w_pick_oh;
  logic [NREQ-1:0] w_mask_set;
  logic            w_in_grant;
  logic            w_release;
  logic            w_revoke;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pad
      if (gi < NREQ) begin : g_used
        assign w_req_pad[gi]  = i_req[gi];
        assign w_elig_pad[gi] = i_req[gi] & ~r_mask[gi];
        assign w_val_pad[gi]  = i_val_in[gi];
        assign w_addr_arr[gi] = i_addr_in[4*gi +: 4];
      end else begin : g_unused
        assign w_req_pad[gi]  = 1'b0;
        assign w_elig_pad[gi] = 1'b0;
        assign w_val_pad[gi]  = 1'b0;
        assign w_addr_arr[gi] = IDLE_ADDR;
      end
    end
    for (gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign w_pick_oh[gi]  = (w_pick_idx == 2'(gi));
      assign w_mask_set[gi] = w_revoke && (r_owner == 2'(gi));
    end
  endgenerate

  // Scan upward from the slot after the last owner, wrapping at NREQ.
  always_comb begin
    w_pick_valid = 1'b0;
    w_pick_idx   = 2'd0;
    w_scan       = r_ptr;
    for (int off = 0; off < NREQ; off++) begin
      w_scan = (w_scan == LAST) ? 2'd0 : w_scan + 2'd1;
      if (!w_pick_valid && w_elig_pad[w_scan]) begin
        w_pick_valid = 1'b1;
        w_pick_idx   = w_scan;
      end
    end
  end

  assign w_in_grant = (r_state == S_GRANT);
  assign w_release  = w_in_grant && !w_req_pad[r_owner];
  assign w_revoke   = w_in_grant && w_req_pad[r_owner] && (r_cnt == HOLD_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_ptr         <= LAST;
      r_owner       <= 2'd0;
      r_gnt         <= '0;
      r_cnt         <= 8'd0;
      r_mask        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_mask <= (r_mask & i_req) | w_mask_set;
      if (w_revoke) begin
        r_timeout_err <= 1'b1;
      end else if (i_clr_err) begin
        r_timeout_err <= 1'b0;
      end
      case (r_state)
        S_IDLE, S_TURN: begin
          if (w_pick_valid) begin
            r_state <= S_GRANT;
            r_gnt   <= w_pick_oh;
            r_owner <= w_pick_idx;
            r_cnt   <= 8'd0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_GRANT: begin
          if (w_release || w_revoke) begin
            r_gnt   <= '0;
            r_ptr   <= r_owner;
            r_state <= S_TURN;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_gnt         = r_gnt;
  assign o_busy        = w_in_grant;
  assign o_owner       = r_owner;
  assign o_timeout_err = r_timeout_err;
  assign o_addr        = w_in_grant ? w_addr_arr[r_owner] : IDLE_ADDR;
  assign o_val         = w_in_grant & w_val_pad[r_owner];

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: expected bus state is queued as each step is
// driven and popped for comparison one cycle later.
module tb_bus_arbiter;

  localparam int NREQ = 3;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] addr_in;
  logic [NREQ-1:0]   val_in;
  logic              clr_err;
  logic [NREQ-1:0]   gnt;
  logic [3:0]        addr;
  logic              val;
  logic              busy;
  logic [1:0]        owner;
  logic              timeout_err;

  bus_arbiter #(.NREQ(NREQ), .TIMEOUT(4), .IDLE_ADDR(4'b1111)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_addr_in(addr_in),
    .i_val_in(val_in), .i_clr_err(clr_err), .o_gnt(gnt), .o_addr(addr),
    .o_val(val), .o_busy(busy), .o_owner(owner), .o_timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [2:0] gnt;
    logic [3:0] addr;
    logic       val;
    logic       busy;
    logic [1:0] owner;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [1:0] model_owner = 2'd0;

  task automatic cmp(input string tag, input string field, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [2:0] egnt, input logic eerr);
    exp_t e;
    e.tag  = tag;
    e.gnt  = egnt;
    e.err  = eerr;
    e.busy = (egnt != 3'b000);
    e.addr = 4'b1111;
    e.val  = 1'b0;
    if (egnt[0]) begin model_owner = 2'd0; e.addr = 4'b1000; e.val = 1'b1; end
    if (egnt[1]) begin model_owner = 2'd1; e.addr = 4'b0101; e.val = 1'b0; end
    if (egnt[2]) begin model_owner = 2'd2; e.addr = 4'b0011; e.val = 1'b1; end
    e.owner = model_owner;
    sb.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = sb.pop_front();
    $display("t=%0t %s req=%b gnt=%b addr=%b val=%b busy=%b owner=%0d err=%b",
             $time, e.tag, req, gnt, addr, val, busy, owner, timeout_err);
    cmp(e.tag, "gnt",   8'(gnt),         8'(e.gnt));
    cmp(e.tag, "addr",  8'(addr),        8'(e.addr));
    cmp(e.tag, "val",   8'(val),         8'(e.val));
    cmp(e.tag, "busy",  8'(busy),        8'(e.busy));
    cmp(e.tag, "owner", 8'(owner),       8'(e.owner));
    cmp(e.tag, "err",   8'(timeout_err), 8'(e.err));
  endtask

  task automatic step(input string tag, input logic [2:0] r, input logic c,
                      input logic [2:0] egnt, input logic eerr);
    req     = r;
    clr_err = c;
    push_exp(tag, egnt, eerr);
    @(posedge clk);
    #1;
    check_front();
    clr_err = 1'b0;
  endtask

  // Reset is asserted between edges and checked before any clock edge arrives.
  task automatic do_reset(input string tag);
    rst_n       = 1'b0;
    model_owner = 2'd0;
    push_exp(tag, 3'b000, 1'b0);
    #1;
    check_front();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b1;
    req     = '0;
    clr_err = 1'b0;
    addr_in = {4'b0011, 4'b0101, 4'b1000};
    val_in  = 3'b101;
    #2;
    do_reset("reset0");

    // Single requester: grant one edge later, bus follows master 0.
    step("m0_grant", 3'b001, 1'b0, 3'b001, 1'b0);
    step("m0_turn",  3'b000, 1'b0, 3'b000, 1'b0);
    step("m0_idle",  3'b000, 1'b0, 3'b000, 1'b0);

    // Rotation 0,1,2,0 with a turnaround between each owner.
    do_reset("reset1");
    step("rr0_g1", 3'b111, 1'b0, 3'b001, 1'b0);
    step("rr0_g2", 3'b111, 1'b0, 3'b001, 1'b0);
    step("rr0_g3", 3'b111, 1'b0, 3'b001, 1'b0);
    step("rr0_tn", 3'b110, 1'b0, 3'b000, 1'b0);
    step("rr1_g1", 3'b111, 1'b0, 3'b010, 1'b0);
    step("rr1_g2", 3'b111, 1'b0, 3'b010, 1'b0);
    step("rr1_g3", 3'b111, 1'b0, 3'b010, 1'b0);
    step("rr1_tn", 3'b101, 1'b0, 3'b000, 1'b0);
    step("rr2_g1", 3'b111, 1'b0, 3'b100, 1'b0);
    step("rr2_g2", 3'b111, 1'b0, 3'b100, 1'b0);
    step("rr2_g3", 3'b111, 1'b0, 3'b100, 1'b0);
    step("rr2_tn", 3'b011, 1'b0, 3'b000, 1'b0);
    step("rr3_g1", 3'b111, 1'b0, 3'b001, 1'b0);
    step("rr3_tn", 3'b000, 1'b0, 3'b000, 1'b0);
    step("rr3_id", 3'b000, 1'b0, 3'b000, 1'b0);

    // Late request from master 0 must not preempt master 1.
    step("np_g1",  3'b010, 1'b0, 3'b010, 1'b0);
    step("np_g2",  3'b011, 1'b0, 3'b010, 1'b0);
    step("np_g3",  3'b011, 1'b0, 3'b010, 1'b0);
    step("np_tn",  3'b001, 1'b0, 3'b000, 1'b0);
    step("np_m0",  3'b001, 1'b0, 3'b001, 1'b0);
    step("np_tn2", 3'b000, 1'b0, 3'b000, 1'b0);
    step("np_id",  3'b000, 1'b0, 3'b000, 1'b0);

    // Master 2 holds past the limit: revoked after four cycles and masked.
    step("to_g1",   3'b100, 1'b0, 3'b100, 1'b0);
    step("to_g2",   3'b100, 1'b0, 3'b100, 1'b0);
    step("to_g3",   3'b100, 1'b0, 3'b100, 1'b0);
    step("to_g4",   3'b100, 1'b0, 3'b100, 1'b0);
    step("to_rev",  3'b100, 1'b0, 3'b000, 1'b1);
    step("to_msk1", 3'b100, 1'b0, 3'b000, 1'b1);
    step("to_msk2", 3'b100, 1'b0, 3'b000, 1'b1);
    step("to_drop", 3'b000, 1'b0, 3'b000, 1'b1);
    step("to_regr", 3'b100, 1'b0, 3'b100, 1'b1);
    step("to_clr",  3'b100, 1'b1, 3'b100, 1'b0);

    // Revoke on the same edge as clr_err: the error stays set.
    step("tc_g3",   3'b100, 1'b0, 3'b100, 1'b0);
    step("tc_g4",   3'b100, 1'b0, 3'b100, 1'b0);
    step("tc_both", 3'b100, 1'b1, 3'b000, 1'b1);
    step("tc_id",   3'b000, 1'b0, 3'b000, 1'b1);

    // Asynchronous reset in the middle of a grant, then master 1 wins.
    step("ar_g1", 3'b001, 1'b0, 3'b001, 1'b1);
    #2;
    req = 3'b110;
    do_reset("ar_rst");
    step("ar_m1", 3'b110, 1'b0, 3'b010, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the processor's 4-bit-addressed transfer bus (bus address plus drive/load strobe `val`) between up to `NREQ` bus masters: the instruction control unit, the program loader and the debug port. Each master issues its own address/strobe sequence. The arbiter grants one master at a time and routes that master's `addr`/`val` onto the bus. It inserts a one-cycle turnaround between owners and revokes a grant held too long.

## Interface
- `NREQ`, 3: number of requesters, 2..4.
- `TIMEOUT`, 64: maximum GRANT cycles before forced revoke, 2..255.
- `IDLE_ADDR`, 4'b1111: bus address driven when no master owns the bus.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in NREQ: per-master request, held high for the whole transfer sequence.
- `addr_in` in 4*NREQ: master i's bus address in bits [4i+3:4i].
- `val_in` in NREQ: master i's bus strobe.
- `clr_err` in 1: synchronous clear of `timeout_err`.
- `gnt` out NREQ: one-hot grant, registered.
- `addr` out 4: bus address to the tri-mux.
- `val` out 1: bus strobe to the tri-mux.
- `busy` out 1: high in GRANT.
- `owner` out 2: index of the current or last granted master, registered.
- `timeout_err` out 1: sticky, set on a forced revoke.

## Operation
- States: IDLE, GRANT, TURN.
  - IDLE: if any eligible `req` is high at an edge, go to GRANT and set `gnt[k]`. Otherwise stay in IDLE.
  - GRANT: if `req[k]` is low at an edge, clear `gnt`, set `ptr`=k and go to TURN.
  - GRANT timeout: if the hold counter reaches `TIMEOUT`-1 while `req[k]` is still high, force a revoke. Clear `gnt`, set `timeout_err`, set `mask[k]`, set `ptr`=k and go to TURN.
  - TURN: lasts exactly 1 cycle. At the exit edge, arbitrate like IDLE: go to GRANT if any eligible requester exists, otherwise go to IDLE.
- Eligible: `req[i]`=1 and `mask[i]`=0. `mask[i]` clears on any edge where `req[i]`=0.
- Round-robin: search from `ptr`+1 modulo `NREQ` upward and take the first eligible master. `ptr` resets to `NREQ`-1, so master 0 wins the first arbitration.
- Bus mux is combinational from state and `owner`:
  - In GRANT: `addr` = `addr_in[owner]` and `val` = `val_in[owner]`.
  - In IDLE and TURN: `addr` = `IDLE_ADDR` and `val` = 0.
- Hold counter: 8 bits. It clears on entry to GRANT and increments each GRANT cycle.
- `clr_err` clears `timeout_err` on the next edge. If a revoke occurs on the same edge, set wins.
- Requests arriving while another master owns the bus wait. A grant is never preempted except by timeout.

## Timing
- Reset values:
  - Outputs: `gnt`=0, `addr`=`IDLE_ADDR`, `val`=0, `busy`=0, `owner`=0, `timeout_err`=0.
  - Internal: state IDLE, `ptr`=`NREQ`-1, counter=0, mask=0.
- Grant latency: with `req` high before edge e in IDLE, `gnt` and `busy` rise after edge e. The master's `addr`/`val` appear on the bus in the same cycle.
- Release: with `req` low before edge e, `gnt` falls after e, and the bus shows `IDLE_ADDR`/0 for exactly one cycle (TURN).
- Owner change, release to next grant: the next master's `gnt` rises after edge e+1. A single requester re-requesting immediately also waits out TURN.
- Maximum grant length is `TIMEOUT` cycles.
- Asynchronous reset mid-GRANT drops `gnt` and `val` immediately, with no TURN cycle.

## Test plan
- Reset release, then `req`=3'b001 → `gnt`=001 one edge later. `addr` follows `addr_in[0]` (e.g. 4'b1000, `val`=1).
- `req`=3'b111 held, each master drops `req` after 3 GRANT cycles and re-raises it after TURN → grant order 0,1,2,0. Exactly one `addr`=4'b1111 / `val`=0 TURN cycle between each grant.
- Master 1 granted, master 0 requests mid-grant → no preemption. Master 0 is granted 2 edges after master 1 releases.
- `TIMEOUT`=4, master 2 holds `req` high → `gnt` drops after 4 GRANT cycles and `timeout_err`=1. Master 2 is not re-granted until its `req` goes low and returns high. Pulse `clr_err` → `timeout_err`=0.
- Assert `reset` low asynchronously mid-GRANT → `gnt`=0, `val`=0 and `addr`=4'b1111 without waiting for a clock edge. After release with `req`=3'b110, master 1 wins.
- Timeout and `clr_err` on the same edge → `timeout_err` remains 1.
